com_uart: RTL

- Serial-port endpoint behind the physical memory controller's COM data/status registers.
- Transmits bytes written by the CPU to COM_DATA_ADDR; reports readiness through COM_STAT_ADDR bits {read_ready, write_ready}.
- Receives bytes from the external RXD line and holds them for the CPU to read.
- Frame format is fixed 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.

---
 rtl/com_uart.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/com_uart.sv
// 8N1 UART endpoint for the COM data/status registers: one-byte transmitter and a
// single-byte receive holding register with sticky overrun and framing-error flags.
module com_uart #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       enable_com_write,
  output logic       com_write_ready,
  output logic [7:0] rx_data,
  output logic       com_read_ready,
  input  logic       int_com_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_shreg_q, tx_shreg_d;

  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shreg_q, rx_shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rd_ready_q, rd_ready_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            rxd_meta_q, rxd_sync_q;

  // State registers
  always_ff @(posedge clk50M) begin
    if (rst) begin
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_shreg_q  <= '0;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shreg_q  <= '0;
      rx_data_q   <= '0;
      rd_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_shreg_q  <= tx_shreg_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shreg_q  <= rx_shreg_d;
      rx_data_q   <= rx_data_d;
      rd_ready_q  <= rd_ready_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rxd_meta_q  <= uart_rxd;
      rxd_sync_q  <= rxd_meta_q;
    end
  end

  // TX next state; strobes outside TxIdle are dropped
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    case (tx_state_q)
      TxIdle: begin
        if (enable_com_write) begin
          tx_state_d = TxStart;
          tx_shreg_d = tx_data;
          tx_cnt_d   = '0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) tx_state_d = TxStop;
          else                  tx_idx_d   = tx_idx_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitLast) begin
          tx_state_d = TxIdle;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // TX outputs
  always_comb begin
    uart_txd        = 1'b1;
    com_write_ready = 1'b0;
    case (tx_state_q)
      TxIdle:  com_write_ready = 1'b1;
      TxStart: uart_txd = 1'b0;
      TxData:  uart_txd = tx_shreg_q[tx_idx_q];
      default: uart_txd = 1'b1;
    endcase
  end

  // RX next state; a byte load on the same edge as an ack wins over the ack
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_idx_d    = rx_idx_q;
    rx_shreg_d  = rx_shreg_q;
    rx_data_d   = rx_data_q;
    rd_ready_d  = int_com_ack ? 1'b0 : rd_ready_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    case (rx_state_q)
      RxIdle: begin
        if (!rxd_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rxd_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shreg_d = {rxd_sync_q, rx_shreg_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = RxStop;
          else                  rx_idx_d   = rx_idx_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d = '0;
          if (rxd_sync_q) begin
            rx_data_d  = rx_shreg_q;
            rd_ready_d = 1'b1;
            if (rd_ready_q && !int_com_ack) overrun_d = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RxWaitHigh;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxWaitHigh: begin
        // Hold off until the line idles so a break yields a single error
        if (rxd_sync_q) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // RX outputs
  always_comb begin
    rx_data        = rx_data_q;
    com_read_ready = rd_ready_q;
    rx_overrun     = overrun_q;
    rx_frame_err   = frame_err_q;
  end

endmodule
